// File: rtl/sos_coeff_update_ctrl.sv
// rtl/sos_coeff_update_ctrl.sv - shadow/active coefficient bank controller for the SOS IIR cascade
//
// Purpose: collects serial coefficient writes into a shadow bank. A commit arms a
// swap, and the whole bank is copied to the active bank at the next sample strobe.
// The cascade therefore never sees a half-updated coefficient set.
// Build option SOS_FLUSH_ON_SWAP_EN: when it is defined, the cascade delay lines are held
// in reset for FLUSH_CYC cycles after every swap.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   sample_en_i         sample strobe from the front end
//   wr_valid_i/ready_o  coefficient write handshake (ready also gates commit)
//   wr_sec_i/idx_i      target section 1..IIR_SOS_NUM, index 0=b0 1=b1 2=b2 3=a1 4=a2
//   wr_data_i           coefficient value
//   commit_i            request bank swap
//   busy_o              swap pending or flush running
//   swap_done_o         one-cycle pulse, new bank live
//   err_o               sticky illegal-write flag, cleared by reset or accepted commit
//   en_o                cascade enable (combinational)
//   iir_rst_no          active-low cascade reset
//   coeff_o             active bank, [section IIR_SOS_NUM:1][index 4:0][COF_WD-1:0]

module sos_coeff_update_ctrl #(
  parameter int IIR_SOS_NUM = 4,
  parameter int COF_WD      = 16,
  parameter int FLUSH_CYC   = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          sample_en_i,
  input  logic                                          wr_valid_i,
  output logic                                          wr_ready_o,
  input  logic [3:0]                                    wr_sec_i,
  input  logic [2:0]                                    wr_idx_i,
  input  logic [COF_WD-1:0]                             wr_data_i,
  input  logic                                          commit_i,
  output logic                                          busy_o,
  output logic                                          swap_done_o,
  output logic                                          err_o,
  output logic                                          en_o,
  output logic                                          iir_rst_no,
  output logic [IIR_SOS_NUM:1][4:0][COF_WD-1:0]         coeff_o
);

  if (IIR_SOS_NUM < 1 || IIR_SOS_NUM > 15 || FLUSH_CYC < 1 || FLUSH_CYC > 15) begin : g_bad_param
    $error("sos_coeff_update_ctrl: IIR_SOS_NUM and FLUSH_CYC must be in 1..15");
  end

`ifdef SOS_FLUSH_ON_SWAP_EN
  typedef enum logic [1:0] {IDLE, ARMED, FLUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARMED} state_t;
`endif

  state_t state_q, state_d;
  logic [IIR_SOS_NUM:1][4:0][COF_WD-1:0] shadow_q;

  logic wr_acc, wr_legal, commit_acc, swap;
  logic next_flush;

  always_comb begin
    wr_acc     = (state_q == IDLE) && wr_valid_i;
    wr_legal   = (wr_sec_i != 4'd0) && (wr_sec_i <= 4'(IIR_SOS_NUM)) && (wr_idx_i <= 3'd4);
    commit_acc = (state_q == IDLE) && commit_i;
    swap       = (state_q == ARMED) && sample_en_i;
  end

`ifdef SOS_FLUSH_ON_SWAP_EN
  logic [3:0] flush_cnt_q;

  // Counts the remaining flush cycles; loaded at the swap edge, so FLUSH lasts
  // exactly FLUSH_CYC cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt_q <= 4'd0;
    end else if (swap) begin
      flush_cnt_q <= 4'(FLUSH_CYC - 1);
    end else if (state_q == FLUSH && flush_cnt_q != 4'd0) begin
      flush_cnt_q <= flush_cnt_q - 4'd1;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    next_flush = 1'b0;
    en_o       = sample_en_i;
    case (state_q)
      IDLE: begin
        if (commit_i) state_d = ARMED;
      end
      ARMED: begin
`ifdef SOS_FLUSH_ON_SWAP_EN
        if (sample_en_i) state_d = FLUSH;
`else
        if (sample_en_i) state_d = IDLE;
`endif
      end
`ifdef SOS_FLUSH_ON_SWAP_EN
      FLUSH: begin
        en_o = 1'b0;
        if (flush_cnt_q == 4'd0) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef SOS_FLUSH_ON_SWAP_EN
    next_flush = (state_d == FLUSH);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      coeff_o     <= '0;
      wr_ready_o  <= 1'b1;
      busy_o      <= 1'b0;
      swap_done_o <= 1'b0;
      err_o       <= 1'b0;
      iir_rst_no  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Loop compare instead of direct indexing keeps out-of-range addresses harmless.
      if (wr_acc && wr_legal) begin
        for (int s = 1; s <= IIR_SOS_NUM; s++) begin
          for (int k = 0; k < 5; k++) begin
            if (wr_sec_i == 4'(s) && wr_idx_i == 3'(k)) shadow_q[s][k] <= wr_data_i;
          end
        end
      end
      if (swap) coeff_o <= shadow_q;
      wr_ready_o  <= (state_d == IDLE);
      busy_o      <= (state_d != IDLE);
      swap_done_o <= swap;
      // A commit clears the flag, but an illegal write in the same cycle re-raises it.
      if (wr_acc && !wr_legal) begin
        err_o <= 1'b1;
      end else if (commit_acc) begin
        err_o <= 1'b0;
      end
      iir_rst_no <= !next_flush;
    end
  end

endmodule

// File: tb/tb_sos_coeff_update_ctrl.sv
// tb/tb_sos_coeff_update_ctrl.sv - scoreboard bench for sos_coeff_update_ctrl
module tb_sos_coeff_update_ctrl;
  localparam int NS = 4;
  localparam int CW = 16;
  localparam int FC = 2;
  localparam int BW = NS * 5 * CW;
  typedef logic [NS:1][4:0][CW-1:0] bank_t;

  logic clk = 1'b0;
  logic rst, sample_en, wr_valid, wr_ready, commit, busy, swap_done, err, en, iir_rst_n;
  logic [3:0] wr_sec;
  logic [2:0] wr_idx;
  logic [CW-1:0] wr_data;
  bank_t coeff;

  always #5 clk = ~clk;

  sos_coeff_update_ctrl #(.IIR_SOS_NUM(NS), .COF_WD(CW), .FLUSH_CYC(FC)) dut (
    .clk_i(clk), .rst_i(rst), .sample_en_i(sample_en), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .wr_sec_i(wr_sec), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .commit_i(commit), .busy_o(busy), .swap_done_o(swap_done), .err_o(err),
    .en_o(en), .iir_rst_no(iir_rst_n), .coeff_o(coeff)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: shadow/active banks, pending-swap flag, flush countdown.
  bank_t sh, act;
  bit    m_armed, m_err, m_swap;
  int    m_flush;
  bank_t exp_q[$];

  task automatic chk(input string name, input logic [BW-1:0] a, input logic [BW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, a, e, $time);
    end
  endtask

  // Monitor: every swap_done pulse must match the bank captured at commit time.
  always @(negedge clk) begin
    if (swap_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL swap_unexpected actual=1 expected=0 at %0t", $time);
      end else begin
        chk("swap_bank", BW'(coeff), BW'(exp_q.pop_front()));
      end
    end
  end

  function automatic bit idle();
    return !m_armed && m_flush == 0;
  endfunction

  task automatic model_edge(input bit wv, input int s, input int i, input logic [CW-1:0] d,
                            input bit c, input bit se);
    m_swap = 1'b0;
    if (m_flush > 0) begin
      m_flush--;
    end else if (m_armed) begin
      if (se) begin
        act     = sh;
        m_armed = 1'b0;
        m_swap  = 1'b1;
`ifdef SOS_FLUSH_ON_SWAP_EN
        m_flush = FC;
`endif
      end
    end else begin
      if (wv && s >= 1 && s <= NS && i <= 4) sh[s][i] = d;
      if (c) m_err = 1'b0;
      if (wv && !(s >= 1 && s <= NS && i <= 4)) m_err = 1'b1;
      if (c) begin
        m_armed = 1'b1;
        exp_q.push_back(sh);
      end
    end
  endtask

  task automatic check_regs();
    chk("wr_ready", BW'(wr_ready), BW'(idle()));
    chk("busy", BW'(busy), BW'(!idle()));
    chk("err", BW'(err), BW'(m_err));
    chk("swap_done", BW'(swap_done), BW'(m_swap));
    chk("iir_rst_n", BW'(iir_rst_n), BW'(m_flush == 0));
    chk("coeff", BW'(coeff), BW'(act));
  endtask

  task automatic cyc(input bit wv, input int s, input int i, input logic [CW-1:0] d,
                     input bit c, input bit se);
    wr_valid  = wv;
    wr_sec    = 4'(s);
    wr_idx    = 3'(i);
    wr_data   = d;
    commit    = c;
    sample_en = se;
    #3;
    chk("en", BW'(en), BW'(se && m_flush == 0));
    @(posedge clk);
    model_edge(wv, s, i, d, c, se);
    #1;
    check_regs();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cyc(0, 1, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 0; commit = 0; sample_en = 0; wr_sec = 0; wr_idx = 0; wr_data = 0;
    @(posedge clk);
    sh = '0; act = '0; m_armed = 0; m_err = 0; m_swap = 0; m_flush = 0;
    exp_q.delete();
    #1;
    chk("rst_wr_ready", BW'(wr_ready), BW'(1));
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_err", BW'(err), BW'(0));
    chk("rst_swap_done", BW'(swap_done), BW'(0));
    chk("rst_iir_rst_n", BW'(iir_rst_n), BW'(0));
    chk("rst_coeff", BW'(coeff), BW'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_iir_rst_n", BW'(iir_rst_n), BW'(1));
  endtask

  initial begin
    int s, i;
    bit wv, c, se;
    logic [CW-1:0] d;
    rst = 1'b1; wr_valid = 0; commit = 0; sample_en = 0; wr_sec = 0; wr_idx = 0; wr_data = 0;
    do_reset();

    // Basic load of section 1
    cyc(1, 1, 0, 16'h1000, 0, 0);
    cyc(1, 1, 1, 16'h2000, 0, 0);
    cyc(1, 1, 2, 16'h1000, 0, 0);
    cyc(1, 1, 3, 16'hC000, 0, 0);
    cyc(1, 1, 4, 16'h0800, 0, 0);
    cyc(0, 1, 0, '0, 1, 0);
    idle_cycles(3);
    cyc(0, 1, 0, '0, 0, 1);
    chk("basic_s1_b1", BW'(coeff[1][1]), BW'(16'h2000));
    chk("basic_s1_a1", BW'(coeff[1][3]), BW'(16'hC000));
    chk("basic_s2_zero", BW'(coeff[2]), BW'(0));
    idle_cycles(FC + 1);

    // Same-cycle write and commit
    cyc(1, 2, 1, 16'h7FFF, 1, 0);
    idle_cycles(2);
    cyc(0, 1, 0, '0, 0, 1);
    chk("same_cycle_s2_b1", BW'(coeff[2][1]), BW'(16'h7FFF));
    idle_cycles(FC + 1);

    // Stall: write held while armed, accepted once idle again
    cyc(0, 1, 0, '0, 1, 0);
    cyc(1, 3, 0, 16'hABCD, 0, 0);
    cyc(1, 3, 0, 16'hABCD, 0, 0);
    cyc(1, 3, 0, 16'hABCD, 0, 1);
    chk("stall_not_in_bank", BW'(coeff[3][0]), BW'(0));
    for (int k = 0; k < FC + 1; k++) cyc(1, 3, 0, 16'hABCD, 0, 0);
    cyc(0, 1, 0, '0, 1, 0);
    cyc(0, 1, 0, '0, 0, 1);
    chk("stall_then_bank", BW'(coeff[3][0]), BW'(16'hABCD));
    idle_cycles(FC + 1);

    // Illegal writes set err without touching the bank; commit clears it
    cyc(1, 0, 0, 16'h1234, 0, 0);
    cyc(1, 1, 5, 16'h5678, 0, 0);
    cyc(1, 5, 0, 16'h9ABC, 0, 0);
    chk("illegal_err", BW'(err), BW'(1));
    cyc(0, 1, 0, '0, 1, 0);
    chk("commit_clears_err", BW'(err), BW'(0));
    cyc(0, 1, 0, '0, 0, 1);
    idle_cycles(FC + 1);

    // Reset while armed aborts the swap
    do_reset();
    cyc(1, 4, 4, 16'h4444, 0, 0);
    cyc(0, 1, 0, '0, 1, 0);
    do_reset();
    cyc(0, 1, 0, '0, 0, 1);
    chk("rst_armed_coeff", BW'(coeff), BW'(0));
    chk("rst_armed_busy", BW'(busy), BW'(0));
    idle_cycles(2);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      wv = ($urandom_range(0, 1) == 1);
      s  = $urandom_range(0, 5);
      i  = $urandom_range(0, 5);
      d  = CW'($urandom);
      c  = ($urandom_range(0, 9) == 0);
      se = ($urandom_range(0, 4) == 0);
      if (c) begin
        s = $urandom_range(1, NS);
        i = $urandom_range(0, 4);
      end
      cyc(wv, s, i, d, c, se);
    end
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, '0, 0, 1);
    idle_cycles(FC + 2);
    chk("scoreboard_drained", BW'(exp_q.size()), BW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sos_coeff_update_ctrl.md
# sos_coeff_update_ctrl

Coefficient-bank controller for the cascade SOS IIR filter. Accepts serial coefficient writes into a shadow bank and commits the whole bank atomically on a sample boundary, so the cascade never runs a sample with a half-updated coefficient set. Optionally flushes the cascade's delay state after each swap. Sits between the register/configuration bus and the cascade's per-section coefficient inputs and enable.

## Interface
Parameters:
- IIR_SOS_NUM, 4, number of cascaded sections; legal 1..15
- COF_WD, 16, coefficient width; package coefficient type TYDE_SOS_COEFF_DATA_COF_WD
- FLUSH_CYC, 2, cycles the cascade reset is held after a swap (flush build only); legal 1..15

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- sample_en_i  in  1  sample strobe from the front end
- wr_valid_i  in  1  coefficient write request
- wr_ready_o  out  1  write/commit acceptance
- wr_sec_i  in  4  target section, 1..IIR_SOS_NUM
- wr_idx_i  in  3  coefficient index: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
- wr_data_i  in  COF_WD  coefficient value
- commit_i  in  1  request bank swap
- busy_o  out  1  commit pending or swap/flush in progress
- swap_done_o  out  1  one-cycle pulse, new bank live
- err_o  out  1  sticky illegal-write flag
- en_o  out  1  enable to the cascade
- iir_rst_no  out  1  active-low reset to the cascade
- coeff_o  out  IIR_SOS_NUM x TYDE_SOS_COEFF_DATA_COF_WD  active bank, index [IIR_SOS_NUM:1]

## Operation
- Two banks, shadow and active, each holding IIR_SOS_NUM x 5 x COF_WD bits. coeff_o is driven directly from the active-bank registers.
- FSM states: IDLE, ARMED, FLUSH (FLUSH exists only in the flush build).
- IDLE:
  - wr_ready_o=1.
  - A write is accepted when wr_valid_i=1. It updates shadow[wr_sec_i][wr_idx_i] at the clock edge.
  - An illegal write (wr_sec_i=0, wr_sec_i>IIR_SOS_NUM, or wr_idx_i>4) is accepted but dropped, and sets err_o.
  - commit_i=1 moves the FSM to ARMED.
  - If a write and a commit arrive in the same cycle, the write is applied and included in the committed bank.
- ARMED:
  - wr_ready_o=0; writes stall and commit_i is ignored.
  - When sample_en_i=1, that sample is processed with the old bank (en_o=1). At the same edge, active <= shadow.
  - FSM then goes to FLUSH in the flush build, otherwise to IDLE.
- FLUSH: iir_rst_no=0 and en_o=0 for FLUSH_CYC cycles, then IDLE. sample_en_i strobes arriving during FLUSH are dropped.
- en_o = sample_en_i in every state except FLUSH.
- busy_o=1 in ARMED and FLUSH.
- err_o is cleared by rst_i or by an accepted commit. A commit proceeds regardless of err_o.
- The shadow bank persists across commits, so partial updates are valid: write only the changed coefficients, then commit.

## Timing
- Reset (rst_i=1 at an edge):
  - Both banks cleared to 0; FSM goes to IDLE.
  - Outputs: wr_ready_o=1, busy_o=0, swap_done_o=0, err_o=0, en_o follows sample_en_i, iir_rst_no=0 while rst_i=1, then 1.
  - Reset in the middle of ARMED or FLUSH aborts the operation with no swap_done_o pulse.
- Write latency: a write accepted at edge N is visible in the shadow bank at N+1. It is never visible on coeff_o before a commit.
- Commit accepted at edge N: busy_o=1 from N+1.
- Swap at the edge where sample_en_i=1 in ARMED (edge S):
  - coeff_o changes after S.
  - swap_done_o=1 during the cycle after S.
  - Non-flush build: busy_o=0 after S.
- Flush build: iir_rst_no=0 and en_o=0 for cycles S+1..S+FLUSH_CYC. busy_o=0 and wr_ready_o=1 after edge S+FLUSH_CYC.
- All outputs are registered except en_o, which is combinational from sample_en_i and state.

## Configuration
- Macro SOS_FLUSH_ON_SWAP_EN.
  - Defined: FLUSH state compiled in. Every swap clears the cascade delay lines, so no transient mixes old state with new coefficients.
  - Undefined: no FLUSH state; iir_rst_no tracks reset only; FLUSH_CYC is unused; delay state carries across the swap.

## Test plan
- Basic load: after reset, write section 1 coefficients b0..a2 = 0x1000, 0x2000, 0x1000, 0xC000, 0x0800, then commit. coeff_o stays 0 until the next sample_en_i. coeff_o[1] then holds those values, swap_done_o pulses once, and sections 2..4 stay 0.
- Same-cycle write and commit: write 0x7FFF to section 2 b1 with commit_i=1 in the same cycle. After the next sample_en_i, coeff_o[2].b1=0x7FFF.
- Stall: send wr_valid_i=1 while ARMED. wr_ready_o=0 and the shadow bank is unchanged until busy_o falls. The held write is then accepted.
- Illegal write: wr_sec_i=0 or wr_idx_i=5. No register changes and err_o=1. The next commit clears err_o.
- Reset in ARMED: assert rst_i one cycle before sample_en_i. There is no swap, coeff_o=0, and busy_o=0.
- Flush build with FLUSH_CYC=2: after the swap, iir_rst_no=0 and en_o=0 for exactly 2 cycles. A sample_en_i arriving in that window does not reach en_o.
